// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, 1-cycle latency from request in IDLE.
// No backpressure: a grant is released on request drop, enab low or hold timeout, then one dead cycle.
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enab,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam bit             TIMED     = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic             state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic [15:0] req_dbl;
   logic [7:0]  req_rot;
   logic        found;
   logic [2:0]  off;
   logic [2:0]  sel;
   logic        release_now;

   // Rotate so that bit 0 of req_rot is the requester at ptr; first set bit wins.
   assign req_dbl = {req, req} >> ptr;
   assign req_rot = req_dbl[7:0];

   always_comb begin
      found = 1'b0;
      off   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            off   = i[2:0];
         end
      end
   end

   assign sel = ptr + off;

   assign release_now = !req[gnt_idx] || !enab || (TIMED && (hold_cnt == HOLD_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= '0;
         gnt       <= 8'h00;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enab && found) begin
                  state     <= ST_GRANT;
                  gnt       <= 8'h01 << sel;
                  gnt_idx   <= sel;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            default: begin
               if (release_now) begin
                  // gnt_idx is left holding the last winner.
                  state     <= ST_IDLE;
                  gnt       <= 8'h00;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_idx + 3'd1;
               end else if (TIMED) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed checks of rr_arbiter_8 across three hold settings (15, 4, unlimited) sharing one stimulus.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enab;
   logic [7:0] req;

   logic [7:0] gnt15, gnt4, gnt0;
   logic [2:0] idx15, idx4, idx0;
   logic       vld15, vld4, vld0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(15), .CNT_W(4)) u15 (
      .clk(clk), .rst(rst), .enab(enab), .req(req),
      .gnt(gnt15), .gnt_idx(idx15), .gnt_valid(vld15));

   rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(3)) u4 (
      .clk(clk), .rst(rst), .enab(enab), .req(req),
      .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4));

   rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .enab(enab), .req(req),
      .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      enab = 1'b1;
      req  = 8'hFF;
      do_reset();
      tests++;
      if ({gnt15, idx15, vld15} !== 12'h000) begin
         fails++;
         $display("FAIL reset_u15: got gnt=%h idx=%0d vld=%b, want 00/0/0", gnt15, idx15, vld15);
      end
      tests++;
      if ({gnt4, idx4, vld4} !== 12'h000) begin
         fails++;
         $display("FAIL reset_u4: got gnt=%h idx=%0d vld=%b, want 00/0/0", gnt4, idx4, vld4);
      end
      tests++;
      if (u15.ptr !== 3'd0) begin
         fails++;
         $display("FAIL reset_ptr: got %0d, want 0", u15.ptr);
      end
   endtask

   task automatic test_basic();
      enab = 1'b1;
      req  = 8'h00;
      do_reset();
      req = 8'h20;
      tick();
      tests++;
      if ({gnt15, idx15, vld15} !== {8'h20, 3'd5, 1'b1}) begin
         fails++;
         $display("FAIL basic_grant: got gnt=%h idx=%0d vld=%b, want 20/5/1", gnt15, idx15, vld15);
      end
      req = 8'h00;
      tick();
      tests++;
      if ({gnt15, idx15, vld15} !== {8'h00, 3'd5, 1'b0}) begin
         fails++;
         $display("FAIL basic_release: got gnt=%h idx=%0d vld=%b, want 00/5/0", gnt15, idx15, vld15);
      end
      tests++;
      if (u15.ptr !== 3'd6) begin
         fails++;
         $display("FAIL basic_ptr: got %0d, want 6", u15.ptr);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] exp;
      enab = 1'b1;
      req  = 8'hFF;
      do_reset();
      // Each requester holds 4 cycles then one dead cycle; k=8 checks the 7->0 wrap.
      for (int k = 0; k < 9; k++) begin
         exp = 8'h01 << (k % 8);
         for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if (gnt4 !== exp || vld4 !== 1'b1 || idx4 !== 3'(k % 8)) begin
               fails++;
               $display("FAIL timeout_hold k=%0d c=%0d: got gnt=%h idx=%0d vld=%b, want %h/%0d/1",
                        k, c, gnt4, idx4, vld4, exp, k % 8);
            end
         end
         tick();
         tests++;
         if (gnt4 !== 8'h00 || vld4 !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle k=%0d: got gnt=%h vld=%b, want 00/0", k, gnt4, vld4);
         end
      end
   endtask

   task automatic test_sole_regrant();
      enab = 1'b1;
      req  = 8'h08;
      do_reset();
      for (int c = 0; c < 4; c++) tick();
      tests++;
      if (gnt4 !== 8'h08) begin
         fails++;
         $display("FAIL sole_hold: got gnt=%h, want 08", gnt4);
      end
      tick();
      tests++;
      if (gnt4 !== 8'h00) begin
         fails++;
         $display("FAIL sole_idle: got gnt=%h, want 00", gnt4);
      end
      tick();
      tests++;
      if (gnt4 !== 8'h08) begin
         fails++;
         $display("FAIL sole_regrant: got gnt=%h, want 08", gnt4);
      end
   endtask

   task automatic test_no_timeout();
      enab = 1'b1;
      req  = 8'h01;
      do_reset();
      for (int c = 0; c < 50; c++) begin
         tick();
         tests++;
         if (gnt0 !== 8'h01 || vld0 !== 1'b1) begin
            fails++;
            $display("FAIL unlimited_hold c=%0d: got gnt=%h vld=%b, want 01/1", c, gnt0, vld0);
         end
      end
      enab = 1'b0;
      tick();
      tests++;
      if (gnt0 !== 8'h00 || vld0 !== 1'b0) begin
         fails++;
         $display("FAIL enab_release: got gnt=%h vld=%b, want 00/0", gnt0, vld0);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         tests++;
         if (gnt0 !== 8'h00) begin
            fails++;
            $display("FAIL enab_low_idle c=%0d: got gnt=%h, want 00", c, gnt0);
         end
      end
      tests++;
      if (u0.ptr !== 3'd1) begin
         fails++;
         $display("FAIL enab_low_ptr: got %0d, want 1", u0.ptr);
      end
   endtask

   task automatic test_wrap();
      enab = 1'b1;
      req  = 8'h04;
      do_reset();
      tick();
      tests++;
      if (gnt15 !== 8'h04 || idx15 !== 3'd2) begin
         fails++;
         $display("FAIL wrap_first: got gnt=%h idx=%0d, want 04/2", gnt15, idx15);
      end
      req = 8'h00;
      tick();
      tests++;
      if (u15.ptr !== 3'd3) begin
         fails++;
         $display("FAIL wrap_ptr: got %0d, want 3", u15.ptr);
      end
      req = 8'h05;
      tick();
      tests++;
      if (gnt15 !== 8'h01 || idx15 !== 3'd0) begin
         fails++;
         $display("FAIL wrap_grant: got gnt=%h idx=%0d, want 01/0", gnt15, idx15);
      end
   endtask

   task automatic test_mid_reset();
      enab = 1'b1;
      req  = 8'h10;
      do_reset();
      tick();
      tests++;
      if (gnt15 !== 8'h10) begin
         fails++;
         $display("FAIL midrst_grant: got gnt=%h, want 10", gnt15);
      end
      rst = 1'b1;
      tick();
      tests++;
      if ({gnt15, idx15, vld15} !== 12'h000 || u15.ptr !== 3'd0) begin
         fails++;
         $display("FAIL midrst_clear: got gnt=%h idx=%0d vld=%b ptr=%0d, want 00/0/0/0",
                  gnt15, idx15, vld15, u15.ptr);
      end
      rst = 1'b0;
      req = 8'h11;
      tick();
      tests++;
      if (gnt15 !== 8'h01 || idx15 !== 3'd0 || vld15 !== 1'b1) begin
         fails++;
         $display("FAIL midrst_regrant: got gnt=%h idx=%0d vld=%b, want 01/0/1", gnt15, idx15, vld15);
      end
   endtask

   task automatic test_no_preempt();
      enab = 1'b1;
      req  = 8'h02;
      do_reset();
      tick();
      req = 8'h42;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if (gnt15 !== 8'h02) begin
            fails++;
            $display("FAIL nopreempt_hold c=%0d: got gnt=%h, want 02", c, gnt15);
         end
      end
      req = 8'h40;
      tick();
      tests++;
      if (gnt15 !== 8'h00) begin
         fails++;
         $display("FAIL nopreempt_dead: got gnt=%h, want 00", gnt15);
      end
      tick();
      tests++;
      if (gnt15 !== 8'h40 || idx15 !== 3'd6) begin
         fails++;
         $display("FAIL nopreempt_next: got gnt=%h idx=%0d, want 40/6", gnt15, idx15);
      end
   endtask

   initial begin
      rst  = 1'b0;
      enab = 1'b0;
      req  = 8'h00;
      test_reset();
      test_basic();
      test_timeout();
      test_sole_regrant();
      test_no_timeout();
      test_wrap();
      test_mid_reset();
      test_no_preempt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
